cache_backing_mem: RTL
======================

// Module: cache_backing_mem
// PURPOSE
//  Memory-side responder for the cache's req/gnt/rvalid bus. It serves single-word read/write requests from a
//  byte-enable single-port RAM, with programmable grant delay, response latency and stall injection.
//  Sits behind the set-associative cache as line-fill/write-through target, and standalone as a bench memory.
// PARAMETERS
//  MEM_WORDS     1024          RAM depth in 32-bit words (power of 2)
//  BASE_ADDR     32'h0000_0000 byte address of word 0; must be aligned to 4*MEM_WORDS
//  GNT_DELAY     0             extra cycles between request sampled and gnt (0..15)
//  RVALID_DELAY  0             extra cycles between gnt and rvalid (0..15)
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, asynchronous, active-high
//  mem_addr_i    in   32  byte address, valid while mem_req_i high
//  mem_wdata_i   in   32  write data
//  mem_we_i      in   1   1=write, 0=read
//  mem_req_i     in   1   request; held by initiator until gnt
//  mem_be_i      in   4   write byte enables (ignored on reads)
//  stall_i       in   1   backpressure injection; blocks gnt while high
//  mem_rdata_o   out  32  read data, valid with rvalid, held until next rvalid
//  mem_gnt_o     out  1   one-cycle grant; request accepted in this cycle
//  mem_rvalid_o  out  1   one-cycle response strobe (reads and writes)
//  mem_error_o   out  1   qualifies rvalid: access was out of range or misaligned
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, counters 0. RAM contents are not cleared and survive reset.
//  FSM states: IDLE, WAIT_GNT, GRANT, LATENCY, RESP.
//   IDLE: if mem_req_i, load dly_ctr=GNT_DELAY and go to WAIT_GNT.
//   WAIT_GNT: if !mem_req_i, go to IDLE (initiator withdrew; no gnt).
//             Otherwise, if dly_ctr!=0, decrement. Otherwise, if !stall_i, go to GRANT; if stall_i, stay.
//   GRANT: mem_gnt_o=1 (combinational decode of state). Latch addr/we/be/wdata.
//          Perform the RAM access at the closing edge: write only the enabled bytes; on a read, RAM data is
//          ready next cycle. Load dly_ctr=RVALID_DELAY, then go to LATENCY.
//   LATENCY: capture RAM read data into rdata register. Decrement dly_ctr to 0, then go to RESP.
//   RESP: mem_rvalid_o=1 and mem_error_o=err flag, both for exactly one cycle. Then go to IDLE.
//  Latency: req first high in cycle C gives gnt in cycle C+1+GNT_DELAY+(stall cycles).
//           Gnt in cycle G gives rvalid in cycle G+2+RVALID_DELAY.
//  Throughput: one outstanding transaction. After RESP there is at least one IDLE cycle, so a req held
//              continuously after rvalid is a new request.
//  Error: fires if addr<BASE_ADDR, addr>=BASE_ADDR+4*MEM_WORDS, or addr[1:0]!=0.
//         No RAM access occurs. rdata_o=0 with rvalid and error=1. The error is still granted and answered.
//  Index: word index = (addr-BASE_ADDR)[log2(MEM_WORDS)+1:2].
//  Writes: mem_be_i=4'b0000 leaves the RAM unchanged; the write is still granted and answered.
//          mem_rdata_o keeps its previous value on a write response.
//  Reads: always return the full word regardless of be.
//  Reset mid-transaction: the pending response is dropped and no rvalid follows. An in-flight RAM write that
//                         committed at the GRANT edge stays committed.
// STRUCTURE
//  Package cache_pkg: mem_resp_state_t enum (5 states), DLY_W=4, bus width constants.
//  Sub-module cache_sp_ram: sync single-port RAM, 32-bit, per-byte write enables, registered read, no reset.
//  Top level holds FSM, dly_ctr, request latch, range check, rdata/err registers.
// TESTING
//  1 GNT_DELAY=0,RVALID_DELAY=0: write 0x0000_0010=0xDEADBEEF be=1111 with req at cycle 0 -> gnt c1, rvalid c3,
//    err=0. Then read the same address -> rdata=0xDEADBEEF.
//  2 Preload 0xAABBCCDD, write 0x11223344 be=0101 -> read returns 0xAA22CC44. Write with be=0000 -> unchanged.
//  3 GNT_DELAY=2,RVALID_DELAY=3: 4-word line fill at 0x40..0x4C, req held to gnt each time -> each gnt 3 cycles
//    after req, rvalid 5 cycles after gnt, data in order, exactly 4 gnts and 4 rvalids.
//  4 stall_i high 5 cycles during a pending req -> no gnt while stalled, a single gnt 1 cycle after stall falls.
//  5 Read at BASE_ADDR+4*MEM_WORDS and at 0x02 -> gnt, rvalid with err=1 and rdata=0. A write there leaves
//    all RAM words unchanged.
//  6 Assert reset between gnt and rvalid of a write -> outputs 0 immediately, no rvalid after release, and
//    the written word reads back correctly.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache memory-side responder.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int DLY_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_GRANT,
    ST_LATENCY,
    ST_RESP
  } mem_resp_state_t;

endpackage

// File: rtl/cache_sp_ram.sv
// Synchronous single-port RAM, 32-bit words, per-byte write enables,
// registered read data. Contents are never reset.
module cache_sp_ram
  import cache_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Byte-masked write or full-word registered read, one access per enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/cache_backing_mem.sv
// Memory-side responder for the req/gnt/rvalid bus. One outstanding
// transaction; programmable grant delay, response latency and stall.
//
// Handshake: the initiator holds mem_req_i (with addr/we/be/wdata stable)
// until it sees mem_gnt_o high; the request is accepted at the clock edge
// that closes the gnt cycle. Exactly one mem_rvalid_o pulse answers every
// granted request (reads, writes and errors alike); mem_error_o and
// mem_rdata_o are meaningful only while mem_rvalid_o is high.
module cache_backing_mem
  import cache_pkg::*;
#(
  parameter int          MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          GNT_DELAY    = 0,
  parameter int          RVALID_DELAY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_we_i,
  input  logic        mem_req_i,
  input  logic [3:0]  mem_be_i,
  input  logic        stall_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic        mem_error_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
  // IDLE already counts as the first waiting cycle, so the counter
  // starts one below the configured delay.
  localparam logic [DLY_W-1:0] GNT_DLY_FIRST =
    (GNT_DELAY == 0) ? '0 : DLY_W'(GNT_DELAY - 1);
  localparam logic [DLY_W-1:0] RV_DLY = DLY_W'(RVALID_DELAY);

  mem_resp_state_t   state;
  logic [DLY_W-1:0]  dly_ctr;
  logic              req_we;
  logic              req_err;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              err_q;

  logic [31:0]       addr_off;
  logic              range_err;
  logic [AW-1:0]     ram_idx;
  logic              ram_en;
  logic [31:0]       ram_rdata;

  // Range/alignment check and word index of the presented address.
  always_comb begin
    addr_off  = mem_addr_i - BASE_ADDR;
    range_err = (mem_addr_i < BASE_ADDR) ||
                ({1'b0, mem_addr_i} >= LIMIT) ||
                (mem_addr_i[1:0] != 2'b00);
    ram_idx   = AW'(addr_off >> 2);
    ram_en    = (state == ST_GRANT) && !range_err;
  end

  cache_sp_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (mem_we_i),
    .be    (mem_be_i),
    .addr  (ram_idx),
    .wdata (mem_wdata_i),
    .rdata (ram_rdata)
  );

  // Responder FSM with delay counter, request latch and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      dly_ctr  <= '0;
      req_we   <= 1'b0;
      req_err  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_req_i) begin
            if (GNT_DELAY == 0 && !stall_i) begin
              state <= ST_GRANT;
            end else begin
              dly_ctr <= GNT_DLY_FIRST;
              state   <= ST_WAIT_GNT;
            end
          end
        end
        ST_WAIT_GNT: begin
          if (!mem_req_i) begin
            state <= ST_IDLE;
          end else if (dly_ctr != '0) begin
            dly_ctr <= dly_ctr - 1'b1;
          end else if (!stall_i) begin
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          req_we  <= mem_we_i;
          req_err <= range_err;
          dly_ctr <= RV_DLY;
          state   <= ST_LATENCY;
        end
        ST_LATENCY: begin
          if (dly_ctr != '0) begin
            dly_ctr <= dly_ctr - 1'b1;
          end else begin
            // Write responses keep the previous read data visible.
            if (req_err) begin
              rdata_q <= '0;
            end else if (!req_we) begin
              rdata_q <= ram_rdata;
            end
            rvalid_q <= 1'b1;
            err_q    <= req_err;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_gnt_o    = (state == ST_GRANT);
  assign mem_rvalid_o = rvalid_q;
  assign mem_error_o  = err_q;
  assign mem_rdata_o  = rdata_q;

endmodule
